// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Arbitrates a single-port data memory between a CPU port and a DMA/loader
// port. Each access runs IDLE -> ACCESS -> DONE: the winner's command is
// latched in IDLE, the memory is strobed for one cycle in ACCESS, and the
// winner receives a one-cycle ack in DONE.
//
// Ports
//   clock, reset            : system clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata   : CPU request and command
//   cpu_rdata, cpu_ack      : CPU read data (read register) and completion pulse
//   cpu_stall               : cpu_req & ~cpu_ack
//   dma_req/we/addr/wdata   : DMA request and command
//   dma_rdata, dma_ack      : DMA read data (read register) and completion pulse
//   mem_addr/wdata/we/re    : data-memory command (strobes only in ACCESS)
//   mem_rdata               : data-memory combinational read data
//
// Configuration
//   DMEM_ARB_CPU_PRIORITY_EN : when defined, CPU wins every tie (fixed
//                              priority) and no last-grant state is kept;
//                              otherwise ties are resolved round-robin.
module dmem_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic [15:0] dma_rdata,
  output logic        dma_ack,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Requester identity: 0 = CPU, 1 = DMA
  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_DMA = 1'b1;

  state_t      state_q, state_d;
  logic        lat_we_q, lat_we_d;
  logic [15:0] lat_addr_q, lat_addr_d;
  logic [15:0] lat_wdata_q, lat_wdata_d;
  logic        lat_id_q, lat_id_d;
  logic [15:0] rdata_q, rdata_d;
  logic        grant_dma;

`ifdef DMEM_ARB_CPU_PRIORITY_EN
  // CPU always wins a tie.
  assign grant_dma = dma_req & ~cpu_req;
`else
  logic last_grant_q, last_grant_d;

  // DMA wins when alone, or on a tie when the CPU was served last.
  assign grant_dma = dma_req & (~cpu_req | (last_grant_q == GRANT_CPU));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) last_grant_q <= GRANT_DMA;
    else       last_grant_q <= last_grant_d;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= 16'h0000;
      lat_wdata_q <= 16'h0000;
      lat_id_q    <= GRANT_CPU;
      rdata_q     <= 16'h0000;
    end else begin
      state_q     <= state_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      lat_id_q    <= lat_id_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_id_d    = lat_id_q;
    rdata_d     = rdata_q;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    cpu_ack     = 1'b0;
    dma_ack     = 1'b0;
`ifndef DMEM_ARB_CPU_PRIORITY_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (cpu_req || dma_req) begin
          lat_id_d    = grant_dma;
          lat_we_d    = grant_dma ? dma_we    : cpu_we;
          lat_addr_d  = grant_dma ? dma_addr  : cpu_addr;
          lat_wdata_d = grant_dma ? dma_wdata : cpu_wdata;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        mem_we = lat_we_q;
        mem_re = ~lat_we_q;
        // Writes leave the read register untouched.
        if (!lat_we_q) rdata_d = mem_rdata;
        state_d = DONE;
      end
      DONE: begin
        cpu_ack = (lat_id_q == GRANT_CPU);
        dma_ack = (lat_id_q == GRANT_DMA);
`ifndef DMEM_ARB_CPU_PRIORITY_EN
        last_grant_d = lat_id_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address/data hold the latched command in every state; only the strobes
  // are confined to ACCESS.
  assign mem_addr  = lat_addr_q;
  assign mem_wdata = lat_wdata_q;
  assign cpu_rdata = rdata_q;
  assign dma_rdata = rdata_q;
  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clock;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ack, cpu_stall;
  logic        dma_req, dma_we;
  logic [15:0] dma_addr, dma_wdata, dma_rdata;
  logic        dma_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int we_cnt  = 0;
  int acc_base;
  int we_base;

  logic [15:0] mem [0:255];

  dmem_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .cpu_stall (cpu_stall),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_rdata (dma_rdata),
    .dma_ack   (dma_ack),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: combinational read, synchronous write.
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clock) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_we || mem_re) acc_cnt <= acc_cnt + 1;
    if (mem_we) we_cnt <= we_cnt + 1;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%04h expected=0x%04h", tag, got, exp);
    end
  endtask

  // Expected winner of the k-th tie after reset (1 = DMA).
  function automatic logic tie_winner_dma(input int k);
`ifdef DMEM_ARB_CPU_PRIORITY_EN
    return 1'b0;
`else
    return (k % 2) == 1;
`endif
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h10] = 16'hBEEF;
    mem[8'h50] = 16'h1111;
    mem[8'h60] = 16'h2222;
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;

    // Reset state
    @(negedge clock);
    check("rst_mem_we", {15'd0, mem_we}, 16'd0);
    check("rst_mem_re", {15'd0, mem_re}, 16'd0);
    check("rst_acks", {14'd0, cpu_ack, dma_ack}, 16'd0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_rdata", cpu_rdata, 16'h0000);
    reset = 1'b0;
    @(negedge clock);

    // CPU-only read of 0x0010
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    #1;
    check("rd_stall_idle", {15'd0, cpu_stall}, 16'd1);
    check("rd_re_idle", {15'd0, mem_re}, 16'd0);
    @(negedge clock);
    check("rd_re_access", {15'd0, mem_re}, 16'd1);
    check("rd_we_access", {15'd0, mem_we}, 16'd0);
    check("rd_addr_access", mem_addr, 16'h0010);
    check("rd_ack_access", {15'd0, cpu_ack}, 16'd0);
    check("rd_stall_access", {15'd0, cpu_stall}, 16'd1);
    @(negedge clock);
    check("rd_cpu_ack", {15'd0, cpu_ack}, 16'd1);
    check("rd_dma_ack", {15'd0, dma_ack}, 16'd0);
    check("rd_cpu_rdata", cpu_rdata, 16'hBEEF);
    check("rd_dma_rdata", dma_rdata, 16'hBEEF);
    check("rd_stall_done", {15'd0, cpu_stall}, 16'd0);
    check("rd_re_done", {15'd0, mem_re}, 16'd0);
    cpu_req = 0;
    @(negedge clock);
    check("rd_ack_after", {15'd0, cpu_ack}, 16'd0);
    check("rd_hold_addr", mem_addr, 16'h0010);

    // DMA-only write 0x1234 -> 0x0020
    we_base = we_cnt;
    dma_req = 1; dma_we = 1; dma_addr = 16'h0020; dma_wdata = 16'h1234;
    @(negedge clock);
    check("wr_we_access", {15'd0, mem_we}, 16'd1);
    check("wr_re_access", {15'd0, mem_re}, 16'd0);
    check("wr_addr", mem_addr, 16'h0020);
    check("wr_data", mem_wdata, 16'h1234);
    check("wr_acks_access", {14'd0, cpu_ack, dma_ack}, 16'd0);
    @(negedge clock);
    check("wr_dma_ack", {15'd0, dma_ack}, 16'd1);
    check("wr_cpu_ack", {15'd0, cpu_ack}, 16'd0);
    check("wr_we_done", {15'd0, mem_we}, 16'd0);
    check("wr_rdata_kept", cpu_rdata, 16'hBEEF);
    dma_req = 0; dma_we = 0;
    @(negedge clock);
    check("wr_mem", mem[8'h20], 16'h1234);
    check("wr_pulses", 16'(we_cnt - we_base), 16'd1);

    // CPU write whose requester drops req during ACCESS
    acc_base = acc_cnt;
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0030; cpu_wdata = 16'h5555;
    @(negedge clock);
    check("drop_we_access", {15'd0, mem_we}, 16'd1);
    cpu_req = 0; cpu_addr = 16'h0031; cpu_wdata = 16'hAAAA;
    @(negedge clock);
    check("drop_cpu_ack", {15'd0, cpu_ack}, 16'd1);
    check("drop_dma_ack", {15'd0, dma_ack}, 16'd0);
    @(negedge clock);
    @(negedge clock);
    check("drop_one_access", 16'(acc_cnt - acc_base), 16'd1);
    check("drop_mem", mem[8'h30], 16'h5555);
    check("drop_ack_gone", {14'd0, cpu_ack, dma_ack}, 16'd0);

    // Reset asserted in the ACCESS cycle of a DMA write
    dma_req = 1; dma_we = 1; dma_addr = 16'h0040; dma_wdata = 16'h7777;
    @(negedge clock);
    check("ra_we_access", {15'd0, mem_we}, 16'd1);
    reset = 1'b1;
    #1;
    check("ra_we_reset", {15'd0, mem_we}, 16'd0);
    check("ra_rdata_reset", cpu_rdata, 16'h0000);
    @(negedge clock);
    check("ra_no_ack", {14'd0, cpu_ack, dma_ack}, 16'd0);
    check("ra_mem_untouched", mem[8'h40], 16'h0000);
    reset = 1'b0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0050;
    @(negedge clock);
    check("ra_tie_addr", mem_addr, 16'h0050);
    @(negedge clock);
    check("ra_tie_cpu_ack", {15'd0, cpu_ack}, 16'd1);
    check("ra_tie_dma_ack", {15'd0, dma_ack}, 16'd0);
    check("ra_tie_rdata", cpu_rdata, 16'h1111);
    cpu_req = 0; dma_req = 0; dma_we = 0;
    @(negedge clock);

    // Continuous simultaneous reads after reset
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0050;
    dma_req = 1; dma_we = 0; dma_addr = 16'h0060;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check($sformatf("tie%0d_addr", k), mem_addr, tie_winner_dma(k) ? 16'h0060 : 16'h0050);
      check($sformatf("tie%0d_re", k), {15'd0, mem_re}, 16'd1);
      @(negedge clock);
      check($sformatf("tie%0d_acks", k), {14'd0, cpu_ack, dma_ack},
            tie_winner_dma(k) ? 16'd1 : 16'd2);
      check($sformatf("tie%0d_rdata", k), dma_rdata, tie_winner_dma(k) ? 16'h2222 : 16'h1111);
      @(negedge clock);
      check($sformatf("tie%0d_idle", k), {14'd0, mem_we, mem_re}, 16'd0);
    end
    cpu_req = 0; dma_req = 0;
    @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, named clock and reset, listed first below.
REQ-002 The block SHALL have these ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  async active-high reset
- cpu_req  in  1  CPU data-access request
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  16  CPU word address
- cpu_wdata  in  16  CPU write data
- cpu_rdata  out  16  CPU read data, valid while cpu_ack=1
- cpu_ack  out  1  one-cycle completion pulse to CPU
- cpu_stall  out  1  cpu_req & ~cpu_ack; freezes CPU PC
- dma_req, dma_we, dma_addr[15:0], dma_wdata[15:0], dma_rdata[15:0], dma_ack  same meanings for the DMA/loader port
- mem_addr  out  16  data-memory address
- mem_wdata  out  16  data-memory write data
- mem_we  out  1  data-memory write enable
- mem_re  out  1  data-memory read enable
- mem_rdata  in  16  data-memory combinational read data

Function
REQ-003 The block SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-004 In IDLE with no request, the FSM SHALL stay in IDLE with mem_we=mem_re=0.
REQ-005 In IDLE with a request, the block SHALL pick a winner, latch its we/addr/wdata and its identity into internal registers, and move to ACCESS.
REQ-006 Arbitration SHALL be round-robin: a single requester always wins; on a simultaneous request, the requester not granted last wins; last_grant resets to DMA, so CPU wins the first tie.
REQ-007 In ACCESS, mem_addr/mem_wdata SHALL come from the latched registers, with mem_we=latched_we and mem_re=~latched_we, for exactly one cycle; the FSM SHALL then move to DONE.
REQ-008 At the end of ACCESS, mem_rdata SHALL be captured into a 16-bit read register (reads only; writes leave it unchanged).
REQ-009 In DONE, the winner's ack SHALL be 1 for exactly one cycle; its rdata output SHALL carry the read register; last_grant SHALL update; the FSM SHALL return to IDLE.
REQ-010 Latency from req sampled in IDLE to ack SHALL be 2 cycles; a request arriving in ACCESS or DONE SHALL wait until the next IDLE.
REQ-011 Requesters SHALL hold req and command stable until ack; the block SHALL ignore command changes after the IDLE latch.
REQ-012 If the winner drops req during ACCESS/DONE, the access SHALL still complete and ack SHALL still pulse.
REQ-013 Outside ACCESS, mem_we and mem_re SHALL be 0 and mem_addr/mem_wdata SHALL hold the latched values.
REQ-014 The non-winning ack SHALL be 0 at all times; cpu_ack and dma_ack SHALL never both be 1.
REQ-015 cpu_rdata and dma_rdata SHALL both continuously drive the read register.

Reset
REQ-016 Reset SHALL force IDLE immediately, aborting any access: mem_we=mem_re=0, both acks 0, all latches and the read register 0x0000, last_grant=DMA.
REQ-017 After reset deasserts, the first rising edge SHALL be treated as IDLE arbitration.

Configuration
REQ-018 With macro DMEM_ARB_CPU_PRIORITY_EN defined, arbitration SHALL be fixed priority (CPU always wins ties) and last_grant SHALL be omitted; without it, REQ-006 round-robin SHALL apply.

Verification
REQ-019 CPU-only read: mem[0x0010]=0xBEEF, cpu_req=1, we=0, addr=0x0010 -> mem_re=1 for one cycle, cpu_ack one cycle later, cpu_rdata=0xBEEF.
REQ-020 DMA-only write: dma_addr=0x0020, wdata=0x1234, we=1 -> one mem_we pulse with addr 0x0020 and data 0x1234; dma_ack 2 cycles after req sampled; cpu_ack=0 throughout.
REQ-021 Continuous simultaneous requests after reset -> grants alternate CPU, DMA, CPU, DMA, one every 3 cycles; with DMEM_ARB_CPU_PRIORITY_EN -> CPU every time.
REQ-022 The bench SHALL check cpu_stall=1 from cpu_req until cpu_ack, then 0.
REQ-023 Reset asserted mid-ACCESS of a write -> mem_we=0 that same cycle, no ack, next grant follows the tie rule of REQ-006.
REQ-024 Winner drops req during ACCESS -> ack still pulses in DONE; no second access is issued.
